// File: rtl/spart_fifo.sv
// spart_fifo: full-duplex UART with TX/RX FIFOs and a 16x-oversampled receiver.
// Ports: clk, rst_n, iocs/iorw/ioaddr/databus bus, rda, tbr, txd, rxd.
module spart_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot for a push into a full FIFO.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module spart_fifo #(
  parameter int          DATA_BITS   = 8,
  parameter int          PARITY      = 0,
  parameter int          STOP_BITS   = 1,
  parameter int          TX_DEPTH    = 8,
  parameter int          RX_DEPTH    = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);
  localparam logic [2:0] DLAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] SLAST = 3'(STOP_BITS - 1);
  localparam logic       ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } st_t;

  // Bus decode
  logic wr, rd, tx_push, rx_pop, div_wr;
  logic [3:0] clr;
  assign wr      = iocs && !iorw;
  assign rd      = iocs && iorw;
  assign tx_push = wr && (ioaddr == 2'b00);
  assign rx_pop  = rd && (ioaddr == 2'b00);
  assign div_wr  = wr && ioaddr[1];
  assign clr     = (wr && ioaddr == 2'b01) ? databus[7:4] : 4'b0;

  // FIFOs
  logic [DATA_BITS-1:0] tx_head, rx_head, rdat_q, rdat_d;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_pop, rx_push;

  spart_fifo_buf #(.W(DATA_BITS), .DEPTH(TX_DEPTH)) u_txf (
    .clk(clk), .rst_n(rst_n), .push_i(tx_push),
    .data_i(databus[DATA_BITS-1:0]), .pop_i(tx_pop),
    .head_o(tx_head), .empty_o(tx_empty), .full_o(tx_full)
  );

  spart_fifo_buf #(.W(DATA_BITS), .DEPTH(RX_DEPTH)) u_rxf (
    .clk(clk), .rst_n(rst_n), .push_i(rx_push),
    .data_i(rdat_q), .pop_i(rx_pop),
    .head_o(rx_head), .empty_o(rx_empty), .full_o(rx_full)
  );

  assign rda = !rx_empty;
  assign tbr = !tx_full;

  // Divisor and baud tick
  logic [15:0] div_q, div_d, cnt_q, cnt_d;
  logic        tick;
  assign tick = (cnt_q == 16'd0);

  always_comb begin
    div_d = div_q;
    if (wr && ioaddr == 2'b10) div_d[7:0]  = databus;
    if (wr && ioaddr == 2'b11) div_d[15:8] = databus;
  end

  always_comb begin
    cnt_d = cnt_q - 16'd1;
    if (div_wr)    cnt_d = div_d;
    else if (tick) cnt_d = div_q;
  end

  // Error flags {txo, rxo, perr, ferr}; a set beats a clear.
  logic [3:0] err_q, err_d;
  logic txo_set, rxo_set, perr_set, ferr_set;
  assign txo_set = tx_push && tx_full && !tx_pop;
  assign rxo_set = rx_push && rx_full && !rx_pop;
  assign err_d   = {txo_set, rxo_set, perr_set, ferr_set} | (err_q & ~clr);

  // RX synchroniser
  logic rx_m_q, rx_s_q;

  // TX FSM
  st_t                  tx_st_q, tx_st_d;
  logic [3:0]           ttk_q, ttk_d;
  logic [2:0]           tbit_q, tbit_d;
  logic [DATA_BITS-1:0] tdat_q, tdat_d;
  logic                 tx_adv, tx_busy, tpar;

  assign tx_adv  = tick && (ttk_q == 4'd15);
  assign tx_busy = (tx_st_q != S_IDLE) || !tx_empty;
  assign tpar    = (^tdat_q) ^ ODD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q <= S_IDLE;
      ttk_q   <= '0;
      tbit_q  <= '0;
      tdat_q  <= '0;
    end else begin
      tx_st_q <= tx_st_d;
      ttk_q   <= ttk_d;
      tbit_q  <= tbit_d;
      tdat_q  <= tdat_d;
    end
  end

  always_comb begin
    tx_st_d = tx_st_q;
    tbit_d  = tbit_q;
    tdat_d  = tdat_q;
    ttk_d   = tick ? ttk_q + 4'd1 : ttk_q;
    if (tx_pop) tdat_d = tx_head;
    unique case (tx_st_q)
      S_IDLE: if (tx_pop) tx_st_d = S_START;
      S_START: if (tx_adv) begin
        tx_st_d = S_DATA;
        tbit_d  = '0;
      end
      S_DATA: if (tx_adv) begin
        tbit_d = tbit_q + 3'd1;
        if (tbit_q == DLAST) begin
          tbit_d  = '0;
          tx_st_d = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end
      S_PAR: if (tx_adv) begin
        tx_st_d = S_STOP;
        tbit_d  = '0;
      end
      S_STOP: if (tx_adv) begin
        tbit_d = tbit_q + 3'd1;
        if (tbit_q == SLAST)
          tx_st_d = tx_pop ? S_START : S_IDLE;
      end
      default: tx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_pop = tx_adv && !tx_empty &&
             ((tx_st_q == S_IDLE) ||
              (tx_st_q == S_STOP && tbit_q == SLAST));
    unique case (tx_st_q)
      S_START: txd = 1'b0;
      S_DATA:  txd = tdat_q[tbit_q];
      S_PAR:   txd = tpar;
      default: txd = 1'b1;
    endcase
  end

  // RX FSM
  st_t        rx_st_q, rx_st_d;
  logic [3:0] rtk_q, rtk_d;
  logic [2:0] rbit_q, rbit_d;
  logic       rpar_q, rpar_d, rmid, rx_done, rexp;

  assign rmid = tick && (rtk_q == 4'd15);
  assign rexp = (^rdat_q) ^ ODD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st_q <= S_IDLE;
      rtk_q   <= '0;
      rbit_q  <= '0;
      rdat_q  <= '0;
      rpar_q  <= 1'b0;
    end else begin
      rx_st_q <= rx_st_d;
      rtk_q   <= rtk_d;
      rbit_q  <= rbit_d;
      rdat_q  <= rdat_d;
      rpar_q  <= rpar_d;
    end
  end

  always_comb begin
    rx_st_d = rx_st_q;
    rbit_d  = rbit_q;
    rdat_d  = rdat_q;
    rpar_d  = rpar_q;
    rtk_d   = tick ? rtk_q + 4'd1 : rtk_q;
    unique case (rx_st_q)
      S_IDLE: begin
        rtk_d = '0;
        if (!rx_s_q) rx_st_d = S_START;
      end
      // Eighth tick is the start-bit centre; a high line there is a glitch.
      S_START: if (tick && rtk_q == 4'd7) begin
        rtk_d  = '0;
        rbit_d = '0;
        rx_st_d = rx_s_q ? S_IDLE : S_DATA;
      end
      S_DATA: if (rmid) begin
        rdat_d[rbit_q] = rx_s_q;
        rbit_d = rbit_q + 3'd1;
        if (rbit_q == DLAST)
          rx_st_d = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR: if (rmid) begin
        rpar_d  = rx_s_q;
        rx_st_d = S_STOP;
      end
      S_STOP: if (rmid) rx_st_d = S_IDLE;
      default: rx_st_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_done  = (rx_st_q == S_STOP) && rmid;
    rx_push  = rx_done;
    ferr_set = rx_done && !rx_s_q;
    perr_set = rx_done && (PARITY != 0) && (rpar_q != rexp);
  end

  // Shared state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= DEFAULT_DIV;
      cnt_q  <= DEFAULT_DIV;
      err_q  <= '0;
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      rx_m_q <= rxd;
      rx_s_q <= rx_m_q;
    end
  end

  // Read mux
  logic [7:0] rdata, rhead;
  always_comb begin
    rhead = '0;
    if (!rx_empty) rhead[DATA_BITS-1:0] = rx_head;
    unique case (ioaddr)
      2'b00: rdata = rhead;
      2'b01: rdata = {err_q, tx_busy, 1'b0, rda, tbr};
      2'b10: rdata = div_q[7:0];
      default: rdata = div_q[15:8];
    endcase
  end

  assign databus = rd ? rdata : 8'hzz;
endmodule

// File: tb/tb_spart_fifo.sv
// tb_spart_fifo: directed bench for spart_fifo.
// u0 is 8N1 with bench-driven rxd; u1 is 8E1 with txd looped to rxd.
module tb_spart_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs [2];
  logic       rw [2];
  logic [1:0] ad [2];
  logic [7:0] wd [2];
  wire  [7:0] db0, db1;
  logic       rda0, tbr0, txd0, rx0;
  logic       rda1, tbr1, txd1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign db0 = (cs[0] && !rw[0]) ? wd[0] : 8'hzz;
  assign db1 = (cs[1] && !rw[1]) ? wd[1] : 8'hzz;

  spart_fifo u0 (
    .clk(clk), .rst_n(rst_n), .iocs(cs[0]), .iorw(rw[0]),
    .ioaddr(ad[0]), .databus(db0), .rda(rda0), .tbr(tbr0),
    .txd(txd0), .rxd(rx0)
  );

  spart_fifo #(.PARITY(2)) u1 (
    .clk(clk), .rst_n(rst_n), .iocs(cs[1]), .iorw(rw[1]),
    .ioaddr(ad[1]), .databus(db1), .rda(rda1), .tbr(tbr1),
    .txd(txd1), .rxd(txd1)
  );

  typedef struct {
    logic       wr;
    logic [1:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic bwr(input int u, input logic [1:0] a,
                     input logic [7:0] d);
    @(negedge clk);
    cs[u] = 1'b1; rw[u] = 1'b0; ad[u] = a; wd[u] = d;
    @(negedge clk);
    cs[u] = 1'b0;
  endtask

  task automatic brd(input int u, input logic [1:0] a,
                     output logic [7:0] d);
    @(negedge clk);
    cs[u] = 1'b1; rw[u] = 1'b1; ad[u] = a;
    #1;
    d = (u == 0) ? db0 : db1;
    @(negedge clk);
    cs[u] = 1'b0; rw[u] = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    @(negedge clk);
    rx0 = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx0 = d[i];
      repeat (16) @(negedge clk);
    end
    rx0 = stop;
    repeat (stop ? 16 : 12) @(negedge clk);
    rx0 = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] r;
  logic [7:0] a5;
  logic [7:0] rxv [9];
  logic       seen;

  initial begin
    vt[0] = '{1'b0, 2'b01, 8'h00, 8'h01};
    vt[1] = '{1'b0, 2'b10, 8'h00, 8'h45};
    vt[2] = '{1'b0, 2'b11, 8'h00, 8'h01};
    vt[3] = '{1'b0, 2'b00, 8'h00, 8'h00};
    vt[4] = '{1'b1, 2'b10, 8'hAB, 8'h00};
    vt[5] = '{1'b0, 2'b10, 8'h00, 8'hAB};
    vt[6] = '{1'b1, 2'b11, 8'hCD, 8'h00};
    vt[7] = '{1'b0, 2'b11, 8'h00, 8'hCD};
    vt[8] = '{1'b0, 2'b01, 8'h00, 8'h01};
    for (int i = 0; i < 9; i++) rxv[i] = 8'(8'h11 * (i + 1));
    for (int u = 0; u < 2; u++) begin
      cs[u] = 1'b0; rw[u] = 1'b0; ad[u] = '0; wd[u] = '0;
    end
    rx0 = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_txd", {7'b0, txd0}, 8'h01);
    chk("rst_rda", {7'b0, rda0}, 8'h00);
    chk("rst_tbr", {7'b0, tbr0}, 8'h01);

    for (int i = 0; i < 9; i++) begin
      if (vt[i].wr) bwr(0, vt[i].a, vt[i].d);
      else begin
        brd(0, vt[i].a, r);
        chk($sformatf("vec%0d", i), r, vt[i].exp);
      end
    end

    // TX overflow with a stalled transmitter
    for (int i = 0; i < 9; i++) begin
      bwr(0, 2'b00, 8'(i));
      if (i == 6) chk("tbr_after7", {7'b0, tbr0}, 8'h01);
      if (i == 7) chk("tbr_after8", {7'b0, tbr0}, 8'h00);
    end
    brd(0, 2'b01, r);
    chk("txo_status", r, 8'h88);

    do_reset();
    @(negedge clk);
    chk("flush_txd", {7'b0, txd0}, 8'h01);
    brd(0, 2'b01, r);
    chk("flush_status", r, 8'h01);

    // A5 serial waveform, div=0
    bwr(0, 2'b10, 8'h00);
    bwr(0, 2'b11, 8'h00);
    bwr(0, 2'b00, 8'hA5);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (!txd0) seen = 1'b1;
    end
    chk("tx_start_seen", {7'b0, seen}, 8'h01);
    a5 = 8'hA5;
    repeat (8) @(negedge clk);
    chk("tx_start", {7'b0, txd0}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      chk($sformatf("tx_bit%0d", i), {7'b0, txd0}, {7'b0, a5[i]});
    end
    repeat (16) @(negedge clk);
    chk("tx_stop", {7'b0, txd0}, 8'h01);
    chk("tx_tbr", {7'b0, tbr0}, 8'h01);
    repeat (20) @(negedge clk);

    // Framing error
    send(8'h5A, 1'b0);
    repeat (30) @(negedge clk);
    brd(0, 2'b01, r);
    chk("ferr_status", r, 8'h13);
    brd(0, 2'b00, r);
    chk("ferr_data", r, 8'h5A);
    bwr(0, 2'b01, 8'h10);
    brd(0, 2'b01, r);
    chk("ferr_clear", r, 8'h01);

    // Short low glitch
    @(negedge clk);
    rx0 = 1'b0;
    repeat (4) @(negedge clk);
    rx0 = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_rda", {7'b0, rda0}, 8'h00);
    brd(0, 2'b01, r);
    chk("glitch_status", r, 8'h01);

    // RX overflow
    for (int i = 0; i < 9; i++) send(rxv[i], 1'b1);
    repeat (10) @(negedge clk);
    brd(0, 2'b01, r);
    chk("rxo_status", r, 8'h43);
    for (int i = 0; i < 8; i++) begin
      brd(0, 2'b00, r);
      chk($sformatf("rx_fifo%0d", i), r, rxv[i]);
    end
    chk("rx_drained", {7'b0, rda0}, 8'h00);

    // Loopback, even parity
    bwr(1, 2'b10, 8'h00);
    bwr(1, 2'b11, 8'h00);
    bwr(1, 2'b00, 8'h3C);
    bwr(1, 2'b00, 8'hC3);
    repeat (500) @(negedge clk);
    chk("loop_rda", {7'b0, rda1}, 8'h01);
    brd(1, 2'b01, r);
    chk("loop_status", r, 8'h03);
    brd(1, 2'b00, r);
    chk("loop_b0", r, 8'h3C);
    brd(1, 2'b00, r);
    chk("loop_b1", r, 8'hC3);
    chk("loop_empty", {7'b0, rda1}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
